// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI responder with oversampled SCK/CS/MOSI, rx word strobe and one-word tx holding register
module spi_slave_port #(
    parameter int              WIDTH       = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] FILL       = 8'hFF
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic             cspol_i,
    input  logic             bp_clock_i,
    input  logic             bp_mosi_i,
    input  logic             bp_cs_i,
    output logic             bp_miso_o,
    output logic             bp_miso_oe_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             tx_underrun_o,
    output logic             state_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE = 1'b0, SEL = 1'b1} state_t;
    state_t                 state_q, state_d;
    logic [1:0]             rst_q;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, armed_q, done_q, full_q, rx_valid_q, underrun_q;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       rx_sh_q, rx_data_q, tx_sh_q, hold_q;
    logic                   sck_s, mosi_s, cs_act, live, lead, trail, sample, shift_e;
    logic                   enter, leave, complete, load, accept;

    // Reset asserts immediately but is released only on a clock edge
    always_ff @(posedge clock_i or negedge reset_ni)
        if (!reset_ni) rst_q <= 2'b00;
        else           rst_q <= {rst_q[0], 1'b1};
    assign rst_n = rst_q[1];

    // Bring the master's asynchronous pins into the clock domain and keep the last SCK for edge detection
    always_ff @(posedge clock_i or negedge rst_n)
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bp_clock_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bp_cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bp_mosi_i};
            sck_prev_q  <= sck_s;
        end

    // Edges only count once SCK has been seen at its idle level while selected
    always_comb begin
        sck_s    = sck_sync_q[SYNC_STAGES-1];
        mosi_s   = mosi_sync_q[SYNC_STAGES-1];
        cs_act   = cspol_i ? !cs_sync_q[SYNC_STAGES-1] : cs_sync_q[SYNC_STAGES-1];
        live     = armed_q && (state_q == SEL) && cs_act;
        lead     = live && (sck_prev_q == cpol_i) && (sck_s != cpol_i);
        trail    = live && (sck_prev_q != cpol_i) && (sck_s == cpol_i);
        sample   = cpha_i ? trail : lead;
        shift_e  = cpha_i ? lead : trail;
        enter    = (state_q == IDLE) && cs_act;
        leave    = (state_q == SEL) && !cs_act;
        complete = sample && (cnt_q == CW'(WIDTH - 1));
        load     = (enter && !cpha_i) || (shift_e && (cpha_i ? (cnt_q == '0) : done_q));
        accept   = tx_valid_i && !full_q;
    end

    // FSM state register
    always_ff @(posedge clock_i or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    // Selection simply follows the synchronized chip select
    always_comb state_d = cs_act ? SEL : IDLE;

    // FSM and datapath outputs
    always_comb begin
        state_o       = (state_q == SEL);
        bp_miso_oe_o  = (state_q == SEL);
        bp_miso_o     = tx_sh_q[WIDTH-1];
        tx_ready_o    = !full_q;
        rx_data_o     = rx_data_q;
        rx_valid_o    = rx_valid_q;
        tx_underrun_o = underrun_q;
    end

    // Shift registers, bit counter and holding register; deselect drops any partial or loaded word
    always_ff @(posedge clock_i or negedge rst_n)
        if (!rst_n) begin
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            tx_sh_q    <= '0;
            hold_q     <= '0;
        end else begin
            armed_q    <= (state_d == SEL) && (armed_q || (sck_s == cpol_i));
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            if (accept) begin
                hold_q <= tx_data_i;
                full_q <= 1'b1;
            end
            if (leave) begin
                cnt_q   <= '0;
                tx_sh_q <= '0;
                done_q  <= 1'b0;
            end else begin
                if (enter) cnt_q <= '0;
                if (sample) begin
                    rx_sh_q <= {rx_sh_q[WIDTH-2:0], mosi_s};
                    cnt_q   <= complete ? '0 : cnt_q + 1'b1;
                end
                if (complete) begin
                    rx_data_q  <= {rx_sh_q[WIDTH-2:0], mosi_s};
                    rx_valid_q <= 1'b1;
                    done_q     <= 1'b1;
                end
                if (load) begin
                    tx_sh_q    <= full_q ? hold_q : FILL;
                    underrun_q <= !full_q;
                    done_q     <= 1'b0;
                    if (full_q) full_q <= 1'b0;
                end else if (shift_e) begin
                    tx_sh_q <= {tx_sh_q[WIDTH-2:0], 1'b0};
                end
            end
        end
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed SPI master stimulus with rx scoreboard and MISO word checks
module tb_spi_slave_port;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, cspol = 1'b1;
    logic       sck = 1'b0, mosi = 1'b0, cs = 1'b1, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, state;
    logic [7:0] rx_data;
    int         n_chk = 0, n_fail = 0, phase = 6;
    int         rxv_cnt = 0, un_cnt = 0, rise_cnt = 0;
    int         r0, u0, q0;
    logic       ready_prev = 1'b1;
    logic [7:0] exp_rx[$];

    always #5 clk = ~clk;

    spi_slave_port dut (
        .clock_i(clk), .reset_ni(rst_n), .cpol_i(cpol), .cpha_i(cpha), .cspol_i(cspol),
        .bp_clock_i(sck), .bp_mosi_i(mosi), .bp_cs_i(cs), .bp_miso_o(miso), .bp_miso_oe_o(miso_oe),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .tx_underrun_o(tx_underrun), .state_o(state)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pops one expected word
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            if (exp_rx.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data);
            end else chk("rx_data", rx_data, exp_rx.pop_front());
        end
        if (tx_underrun) un_cnt++;
        if (tx_ready && !ready_prev) rise_cnt++;
        ready_prev = tx_ready;
    end

    task automatic check_reset();
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_state", state, 0);
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sck  = p;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_set(input logic act);
        cs = cspol ? ~act : act;
        repeat (8) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        int k = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: got no tx_ready expected tx_ready for %0h", d);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, input logic [7:0] exp_mi);
        logic [7:0] mi = 8'h00;
        if (nbits == 8) exp_rx.push_back(mo);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mo[7-i];
                repeat (phase) @(negedge clk);
                mi  = {mi[6:0], miso};
                sck = ~cpol;
                repeat (phase) @(negedge clk);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mo[7-i];
                repeat (phase) @(negedge clk);
                mi  = {mi[6:0], miso};
                sck = cpol;
                repeat (phase) @(negedge clk);
            end
        end
        if (!cpha) repeat (phase) @(negedge clk);
        if (nbits == 8) chk("miso_word", mi, exp_mi);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Mode 0, preloaded 0xA5; a filler word covers the post-word load point and is then dropped
        set_mode(0, 0);
        push(8'hA5);
        chk("t1_ready_low", tx_ready, 0);
        r0 = rxv_cnt; u0 = un_cnt;
        cs_set(1);
        chk("t1_oe", miso_oe, 1);
        chk("t1_state", state, 1);
        fork
            xfer(8'h3C, 8, 8'hA5);
            push(8'h77);
        join
        cs_set(0);
        chk("t1_rx_valid_count", rxv_cnt - r0, 1);
        chk("t1_underrun_count", un_cnt - u0, 0);
        chk("t1_oe_off", miso_oe, 0);

        // Mode 3, two back-to-back words with the second tx word pushed mid-transfer
        set_mode(1, 1);
        r0 = rxv_cnt; u0 = un_cnt; q0 = rise_cnt;
        push(8'h12);
        cs_set(1);
        fork
            begin
                xfer(8'hC3, 8, 8'h12);
                xfer(8'h5A, 8, 8'h34);
            end
            push(8'h34);
        join
        cs_set(0);
        chk("t2_rx_valid_count", rxv_cnt - r0, 2);
        chk("t2_underrun_count", un_cnt - u0, 0);
        chk("t2_ready_rises", rise_cnt - q0, 2);

        // Mode 1 with nothing queued: FILL goes out with one underrun
        set_mode(0, 1);
        r0 = rxv_cnt; u0 = un_cnt;
        cs_set(1);
        xfer(8'h00, 8, 8'hFF);
        cs_set(0);
        chk("t3_underrun_count", un_cnt - u0, 1);
        chk("t3_rx_valid_count", rxv_cnt - r0, 1);

        // Mode 0, aborted 5-bit transfer then a full word using the word held across it
        set_mode(0, 0);
        r0 = rxv_cnt;
        cs_set(1);
        push(8'h5E);
        xfer(8'hAA, 5, 8'h00);
        cs_set(0);
        chk("t4_partial_no_rx", rxv_cnt - r0, 0);
        chk("t4_held_word", tx_ready, 0);
        cs_set(1);
        xfer(8'h81, 8, 8'h5E);
        cs_set(0);
        chk("t4_rx_valid_count", rxv_cnt - r0, 1);

        // Reset in the middle of a transfer, released with CS still asserted
        cs_set(1);
        xfer(8'hB0, 3, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_state_after_release", state, 1);
        xfer(8'hE7, 8, 8'hFF);
        cs_set(0);

        // Active-high CS at the minimum legal SCK phase
        cs = 1'b0;
        cspol = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_idle", state, 0);
        push(8'h69);
        phase = 4;
        cs_set(1);
        chk("t6_selected", state, 1);
        xfer(8'h96, 8, 8'h69);
        cs_set(0);
        phase = 6;

        repeat (10) @(negedge clk);
        chk("rx_queue_drained", exp_rx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
